mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU load/store front end for a word-wide data memory (DMEM).
//   latency: load 2, word store 2, byte/half store 4 cycles from acceptance to resp_valid.
//   backpressure: req_ready only in IDLE; requests in other states are ignored; resp has no backpressure.
// Ports: req_* CPU request (valid/ready), resp_* one-cycle completion pulse with held data/err,
//        DMEM_* word-indexed memory port (combinational read data, write on strobe rising edge).
// Optional macro MISALIGN_TRAP_EN: misaligned half/word and reserved size complete with resp_err=1
// and no memory access. Undefined: resp_err stays 0, misaligned low bits ignored, size 11 acts as word.
module mem_access_ctrl #(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] DMEM_address,
   output logic [31:0] DMEM_data_in,
   output logic        DMEM_mem_write,
   output logic        DMEM_mem_read,
   input  logic [31:0] DMEM_data_out
);

   typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [1:0]          size_q, size_d;
   logic [1:0]          lane_q, lane_d;
   logic                write_q, write_d;
   logic                uns_q, uns_d;
   logic                err_q, err_d;
   logic                mem_write_q, mem_write_d;

   logic [1:0]          acc_size;
   logic [1:0]          acc_lane;
   logic                trap;
   logic [4:0]          sh;
   logic [31:0]         ext_data;
   logic [31:0]         merged;
   logic [31:0]         lane_mask;
   logic [31:0]         lane_ins;

   wire unused_addr_hi = ^req_addr[31:ADDR_W+2];

   // Reserved size behaves as word; the lane is normalised so later shifts
   // never see misaligned low bits for half/word accesses.
   always_comb begin
      acc_size = (req_size == 2'b11) ? 2'b10 : req_size;
      case (acc_size)
         2'b00:   acc_lane = req_addr[1:0];
         2'b01:   acc_lane = {req_addr[1], 1'b0};
         default: acc_lane = 2'b00;
      endcase
`ifdef MISALIGN_TRAP_EN
      trap = (req_size == 2'b11) ||
             ((req_size == 2'b01) && req_addr[0]) ||
             ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
      trap = 1'b0;
`endif
   end

   // Lane extraction for loads and lane replacement for sub-word stores,
   // both working on the combinational memory read word.
   always_comb begin
      sh = {lane_q, 3'b000};
      case (size_q)
         2'b00:   ext_data = uns_q ? {24'b0, DMEM_data_out[sh +: 8]}
                                   : {{24{DMEM_data_out[sh + 5'd7]}}, DMEM_data_out[sh +: 8]};
         2'b01:   ext_data = uns_q ? {16'b0, DMEM_data_out[{lane_q[1], 4'b0000} +: 16]}
                                   : {{16{DMEM_data_out[{lane_q[1], 4'b1111}]}},
                                      DMEM_data_out[{lane_q[1], 4'b0000} +: 16]};
         default: ext_data = DMEM_data_out;
      endcase
      lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      lane_ins  = ((size_q == 2'b00) ? {24'b0, wdata_q[7:0]} : {16'b0, wdata_q[15:0]}) << sh;
      merged    = (DMEM_data_out & ~lane_mask) | lane_ins;
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      size_d      = size_q;
      lane_d      = lane_q;
      write_d     = write_q;
      uns_d       = uns_q;
      err_d       = err_q;
      mem_write_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr[ADDR_W+1:2];
               wdata_d = req_wdata;
               size_d  = acc_size;
               lane_d  = acc_lane;
               write_d = req_write;
               uns_d   = req_unsigned;
               if (trap) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = 32'b0;
               end else if (req_write && (acc_size == 2'b10)) begin
                  state_d     = WR;
                  mem_write_d = 1'b1;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            if (write_q) begin
               // Merge at the end of RD so DMEM_data_in is settled for the
               // whole MERGE cycle before the strobe rises entering WR.
               wdata_d = merged;
               state_d = MERGE;
            end else begin
               rdata_d = ext_data;
               err_d   = 1'b0;
               state_d = RESP;
            end
         end
         MERGE: begin
            state_d     = WR;
            mem_write_d = 1'b1;
         end
         WR: begin
            rdata_d = 32'b0;
            err_d   = 1'b0;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= 32'b0;
         rdata_q     <= 32'b0;
         size_q      <= 2'b00;
         lane_q      <= 2'b00;
         write_q     <= 1'b0;
         uns_q       <= 1'b0;
         err_q       <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         size_q      <= size_d;
         lane_q      <= lane_d;
         write_q     <= write_d;
         uns_q       <= uns_d;
         err_q       <= err_d;
         mem_write_q <= mem_write_d;
      end
   end

   assign req_ready      = (state_q == IDLE);
   assign resp_valid     = (state_q == RESP);
   assign DMEM_mem_read  = (state_q == RD);
   assign DMEM_mem_write = mem_write_q;
   assign DMEM_address   = {{(32-ADDR_W){1'b0}}, addr_q};
   assign DMEM_data_in   = wdata_q;
   assign resp_rdata     = rdata_q;
   assign resp_err       = err_q;

endmodule
